simple_fixed_pipe: RTL and testbench

SIMPLE_FIXED_PIPE -- requirements
Module: simple_fixed_pipe

---
 rtl/spu_pkg.sv | 70 +++++++
 rtl/simple_fixed_pipe_if.sv | 41 ++++
 rtl/simple_fixed_alu.sv | 71 +++++++
 rtl/simple_fixed_pipe.sv | 81 ++++++++
 tb/tb_simple_fixed_pipe.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/spu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spu_pkg
// Description : Shared definitions for the fixed-point pipe: opcode encodings,
//               instruction formats, the per-stage record and lane helpers.
// Revision    : 1.0  initial release
// ============================================================================
package spu_pkg;

    localparam int REG_BITS = 128;

    // Instruction formats; every other encoding issues a bubble.
    typedef enum logic [2:0] {
        FMT_RR   = 3'd0,
        FMT_RI10 = 3'd3
    } fmt_e;

    // RR opcodes (all 11 bits, op[0] is the leftmost/most significant bit)
    localparam logic [0:10] OP_NOP  = 11'b00000000000;
    localparam logic [0:10] OP_AH   = 11'b00011001000;
    localparam logic [0:10] OP_A    = 11'b00011000000;
    localparam logic [0:10] OP_SFH  = 11'b00001001000;
    localparam logic [0:10] OP_SF   = 11'b00001000000;
    localparam logic [0:10] OP_AND  = 11'b00011000001;
    localparam logic [0:10] OP_OR   = 11'b00001000001;
    localparam logic [0:10] OP_XOR  = 11'b01001000001;
    localparam logic [0:10] OP_NAND = 11'b00011001001;
    localparam logic [0:10] OP_NOR  = 11'b00001001001;

    // RI10 opcodes (op[0:7] only)
    localparam logic [0:7] OP_AHI = 8'b00011101;
    localparam logic [0:7] OP_AI  = 8'b00011100;

    // One pipeline stage: result, destination address, write enable.
    typedef struct packed {
        logic [0:REG_BITS-1] rt;
        logic [0:6]          addr;
        logic                wr;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '0;

    // Eight independent 16-bit lanes; carries never cross a lane boundary.
    function automatic logic [0:REG_BITS-1] lanes16(input logic [0:REG_BITS-1] a,
                                                    input logic [0:REG_BITS-1] b,
                                                    input logic                sub);
        logic [0:REG_BITS-1] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[16*i +: 16] = sub ? (a[16*i +: 16] - b[16*i +: 16])
                                : (a[16*i +: 16] + b[16*i +: 16]);
        end
        return r;
    endfunction

    // Four independent 32-bit lanes.
    function automatic logic [0:REG_BITS-1] lanes32(input logic [0:REG_BITS-1] a,
                                                    input logic [0:REG_BITS-1] b,
                                                    input logic                sub);
        logic [0:REG_BITS-1] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[32*i +: 32] = sub ? (a[32*i +: 32] - b[32*i +: 32])
                                : (a[32*i +: 32] + b[32*i +: 32]);
        end
        return r;
    endfunction

endpackage : spu_pkg
`default_nettype wire

// File: rtl/simple_fixed_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : simple_fixed_pipe_if
// Description : Issue/writeback bundle of the fixed-point pipe.
//               master : drives op, format, rt_addr, ra, rb, imm, reg_write,
//                        flush; observes writeback and forwarding outputs.
//               slave  : the pipe itself.
//               fwd_* are DEPTH entries, entry 0 is the youngest stage.
// Revision    : 1.0  initial release
// ============================================================================
interface simple_fixed_pipe_if #(
    parameter int DEPTH = 2
);
    logic [0:10]                op;
    logic [2:0]                 format;
    logic [0:6]                 rt_addr;
    logic [0:127]               ra;
    logic [0:127]               rb;
    logic [0:17]                imm;
    logic                       reg_write;
    logic                       flush;

    logic [0:127]               rt_wb;
    logic [0:6]                 rt_addr_wb;
    logic                       reg_write_wb;

    logic [DEPTH-1:0][0:127]    fwd_rt;
    logic [DEPTH-1:0][0:6]      fwd_addr;
    logic [DEPTH-1:0]           fwd_wr;

    modport master (
        output op, format, rt_addr, ra, rb, imm, reg_write, flush,
        input  rt_wb, rt_addr_wb, reg_write_wb, fwd_rt, fwd_addr, fwd_wr
    );

    modport slave (
        input  op, format, rt_addr, ra, rb, imm, reg_write, flush,
        output rt_wb, rt_addr_wb, reg_write_wb, fwd_rt, fwd_addr, fwd_wr
    );
endinterface : simple_fixed_pipe_if
`default_nettype wire

// File: rtl/simple_fixed_alu.sv
`default_nettype none
// ============================================================================
// Module      : simple_fixed_alu
// Description : Purely combinational execute unit of the fixed-point pipe.
//   i_op     [0:10]  decoded opcode
//   i_format [2:0]   instruction format (RR / RI10)
//   i_ra/i_rb[0:127] source operands
//   i_imm    [0:17]  immediate, I10 lives in [8:17]
//   o_result [0:127] computed value
//   o_valid          1 when op/format is a supported instruction
// Revision    : 1.0  initial release
// ============================================================================
module simple_fixed_alu
    import spu_pkg::*;
(
    input  logic [0:10]  i_op,
    input  logic [2:0]   i_format,
    input  logic [0:127] i_ra,
    input  logic [0:127] i_rb,
    input  logic [0:17]  i_imm,
    output logic [0:127] o_result,
    output logic         o_valid
);

    logic [0:15]  w_imm_h;
    logic [0:31]  w_imm_w;
    logic [0:127] w_imm_h_vec;
    logic [0:127] w_imm_w_vec;
    logic         w_unused_imm;

    // I10 is sign-extended to the lane width, then replicated per lane.
    assign w_imm_h      = {{6{i_imm[8]}}, i_imm[8:17]};
    assign w_imm_w      = {{22{i_imm[8]}}, i_imm[8:17]};
    assign w_imm_h_vec  = {8{w_imm_h}};
    assign w_imm_w_vec  = {4{w_imm_w}};
    assign w_unused_imm = ^i_imm[0:7];

    always_comb begin
        o_result = '0;
        o_valid  = 1'b0;
        if (i_format == FMT_RR) begin
            o_valid = 1'b1;
            case (i_op)
                OP_AH:   o_result = lanes16(i_ra, i_rb, 1'b0);
                OP_A:    o_result = lanes32(i_ra, i_rb, 1'b0);
                // Subtract-from: the result is rb minus ra.
                OP_SFH:  o_result = lanes16(i_rb, i_ra, 1'b1);
                OP_SF:   o_result = lanes32(i_rb, i_ra, 1'b1);
                OP_AND:  o_result = i_ra & i_rb;
                OP_OR:   o_result = i_ra | i_rb;
                OP_XOR:  o_result = i_ra ^ i_rb;
                OP_NAND: o_result = ~(i_ra & i_rb);
                OP_NOR:  o_result = ~(i_ra | i_rb);
                // nop and any unknown encoding fall here
                default: o_valid  = 1'b0;
            endcase
        end else if (i_format == FMT_RI10) begin
            o_valid = 1'b1;
            case (i_op[0:7])
                OP_AHI:  o_result = lanes16(i_ra, w_imm_h_vec, 1'b0);
                OP_AI:   o_result = lanes32(i_ra, w_imm_w_vec, 1'b0);
                default: o_valid  = 1'b0;
            endcase
        end
        if (!o_valid) begin
            o_result = '0;
        end
    end

endmodule : simple_fixed_alu
`default_nettype wire

// File: rtl/simple_fixed_pipe.sv
`default_nettype none
// ============================================================================
// Module      : simple_fixed_pipe
// Description : Fixed-latency SIMD integer pipe. The ALU result is captured
//               into stage 0 at issue and shifts one stage per cycle; the
//               writeback outputs are the contents of stage DEPTH-1.
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset, clears every stage
//   bus    : simple_fixed_pipe_if.slave (issue inputs, flush, writeback and
//            per-stage forwarding outputs)
// Revision    : 1.0  initial release
// ============================================================================
module simple_fixed_pipe
    import spu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int REG_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    simple_fixed_pipe_if.slave bus
);

    logic [0:REG_W-1] w_result;
    logic             w_valid;
    stage_t           w_issue;
    stage_t           r_stage [DEPTH];

    simple_fixed_alu u_alu (
        .i_op     (bus.op),
        .i_format (bus.format),
        .i_ra     (bus.ra),
        .i_rb     (bus.rb),
        .i_imm    (bus.imm),
        .o_result (w_result),
        .o_valid  (w_valid)
    );

    // A valid op keeps its address and result even when reg_write is low;
    // only unsupported encodings collapse to a full bubble.
    always_comb begin
        w_issue = STAGE_BUBBLE;
        if (w_valid) begin
            w_issue.rt   = w_result;
            w_issue.addr = bus.rt_addr;
            w_issue.wr   = bus.reg_write;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stage[k] <= STAGE_BUBBLE;
            end
        end else if (bus.flush) begin
            // The instruction issuing this cycle is discarded as well.
            for (int k = 0; k < DEPTH; k++) begin
                r_stage[k] <= STAGE_BUBBLE;
            end
        end else begin
            r_stage[0] <= w_issue;
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign bus.rt_wb        = r_stage[DEPTH-1].rt;
    assign bus.rt_addr_wb   = r_stage[DEPTH-1].addr;
    assign bus.reg_write_wb = r_stage[DEPTH-1].wr;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            bus.fwd_rt[k]   = r_stage[k].rt;
            bus.fwd_addr[k] = r_stage[k].addr;
            bus.fwd_wr[k]   = r_stage[k].wr;
        end
    end

endmodule : simple_fixed_pipe
`default_nettype wire

// File: tb/tb_simple_fixed_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_simple_fixed_pipe
// Description : Directed self-checking bench. Three pipes (DEPTH 2, 3, 4)
//               receive the same issue stream; each check compares against a
//               hand-computed value.
// Revision    : 1.0  initial release
// ============================================================================
module tb_simple_fixed_pipe;

    localparam logic [0:10] T_AH   = 11'b00011001000;
    localparam logic [0:10] T_A    = 11'b00011000000;
    localparam logic [0:10] T_SFH  = 11'b00001001000;
    localparam logic [0:10] T_SF   = 11'b00001000000;
    localparam logic [0:10] T_AND  = 11'b00011000001;
    localparam logic [0:10] T_OR   = 11'b00001000001;
    localparam logic [0:10] T_XOR  = 11'b01001000001;
    localparam logic [0:10] T_NAND = 11'b00011001001;
    localparam logic [0:10] T_NOR  = 11'b00001001001;
    localparam logic [0:10] T_AI   = {8'b00011100, 3'b101};
    localparam logic [0:10] T_AHI  = {8'b00011101, 3'b000};
    localparam logic [0:10] T_NOP  = 11'b00000000000;

    localparam logic [0:127] X  = {8{16'hF0F0}};
    localparam logic [0:127] Y  = {8{16'hFF00}};
    localparam logic [0:127] Z0 = '0;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    simple_fixed_pipe_if #(.DEPTH(2)) if2 ();
    simple_fixed_pipe_if #(.DEPTH(3)) if3 ();
    simple_fixed_pipe_if #(.DEPTH(4)) if4 ();

    simple_fixed_pipe #(.DEPTH(2), .REG_W(128)) u_d2 (.clk(clk), .reset(reset), .bus(if2.slave));
    simple_fixed_pipe #(.DEPTH(3), .REG_W(128)) u_d3 (.clk(clk), .reset(reset), .bus(if3.slave));
    simple_fixed_pipe #(.DEPTH(4), .REG_W(128)) u_d4 (.clk(clk), .reset(reset), .bus(if4.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [0:10] op, input logic [2:0] fmt, input logic [0:6] addr,
                         input logic [0:127] a, input logic [0:127] b,
                         input logic [0:17] imm, input logic rw);
        if2.op = op; if2.format = fmt; if2.rt_addr = addr; if2.ra = a; if2.rb = b; if2.imm = imm; if2.reg_write = rw;
        if3.op = op; if3.format = fmt; if3.rt_addr = addr; if3.ra = a; if3.rb = b; if3.imm = imm; if3.reg_write = rw;
        if4.op = op; if4.format = fmt; if4.rt_addr = addr; if4.ra = a; if4.rb = b; if4.imm = imm; if4.reg_write = rw;
    endtask

    task automatic set_flush(input logic f);
        if2.flush = f;
        if3.flush = f;
        if4.flush = f;
    endtask

    // Writeback triple of the DEPTH=2 pipe.
    task automatic wb2(input string tag, input logic [0:127] rt, input logic [0:6] addr, input logic wr);
        check({tag, "_rt"},   if2.rt_wb,        rt);
        check({tag, "_addr"}, if2.rt_addr_wb,   addr);
        check({tag, "_wr"},   if2.reg_write_wb, wr);
    endtask

    initial begin
        set_flush(1'b0);
        issue(T_NOP, 3'd0, 7'd0, Z0, Z0, 18'd0, 1'b0);

        // ---------------- reset state
        tick();
        tick();
        wb2("reset", Z0, 7'd0, 1'b0);
        check("reset_d4_fwd_rt", if4.fwd_rt, '0);
        check("reset_d4_fwd_wr", if4.fwd_wr, '0);
        reset = 1'b0;

        // ---------------- ah 0x7FFF + 0x0001 per halfword
        issue(T_AH, 3'd0, 7'd9, {8{16'h7FFF}}, {8{16'h0001}}, 18'd0, 1'b1);
        tick();
        check("ah_fwd_addr0", if2.fwd_addr[0], 7'd9);
        check("ah_fwd_rt0",   if2.fwd_rt[0], {8{16'h8000}});
        check("ah_latency",   if2.reg_write_wb, 1'b0);
        issue(T_NOP, 3'd0, 7'd3, X, Y, 18'd0, 1'b1);
        tick();
        wb2("ah", {8{16'h8000}}, 7'd9, 1'b1);
        check("nop_fwd_wr0", if2.fwd_wr[0], 1'b0);

        // ---------------- ai with I10 = -1, upper imm/op bits are don't-care
        issue(T_AI, 3'd3, 7'd5, Z0, X, {8'hAB, 10'h3FF}, 1'b1);
        tick();
        issue(T_NOP, 3'd0, 7'd0, Z0, Z0, 18'd0, 1'b0);
        tick();
        wb2("ai_d2", {4{32'hFFFFFFFF}}, 7'd5, 1'b1);
        tick();
        check("ai_d3_rt",   if3.rt_wb, {4{32'hFFFFFFFF}});
        check("ai_d3_addr", if3.rt_addr_wb, 7'd5);
        check("ai_d3_wr",   if3.reg_write_wb, 1'b1);
        wb2("nop_d2", Z0, 7'd0, 1'b0);

        // ---------------- back-to-back stream, results lag by 2
        issue(T_AHI, 3'd3, 7'd3, {8{16'h0005}}, Z0, {8'h00, 10'h3F0}, 1'b1);
        tick();
        issue(T_SF, 3'd0, 7'd1, {4{32'h0000000A}}, {4{32'h00000003}}, 18'd0, 1'b1);
        tick();
        wb2("ahi", {8{16'hFFF5}}, 7'd3, 1'b1);
        issue(T_SFH, 3'd0, 7'd2, {4{32'h0000000A}}, {4{32'h00000003}}, 18'd0, 1'b1);
        tick();
        wb2("sf", {4{32'hFFFFFFF9}}, 7'd1, 1'b1);
        issue(T_AND, 3'd0, 7'd4, X, Y, 18'd0, 1'b1);
        tick();
        wb2("sfh", {4{32'h0000FFF9}}, 7'd2, 1'b1);
        issue(T_OR, 3'd0, 7'd6, X, Y, 18'd0, 1'b1);
        tick();
        wb2("and", {8{16'hF000}}, 7'd4, 1'b1);
        issue(T_XOR, 3'd0, 7'd7, X, Y, 18'd0, 1'b1);
        tick();
        wb2("or", {8{16'hFFF0}}, 7'd6, 1'b1);
        issue(T_NAND, 3'd0, 7'd8, X, Y, 18'd0, 1'b1);
        tick();
        wb2("xor", {8{16'h0FF0}}, 7'd7, 1'b1);
        issue(T_NOR, 3'd0, 7'd10, X, Y, 18'd0, 1'b1);
        tick();
        wb2("nand", {8{16'h0FFF}}, 7'd8, 1'b1);
        issue(T_A, 3'd0, 7'd11, {4{32'h0001FFFF}}, {4{32'h00000001}}, 18'd0, 1'b1);
        tick();
        wb2("nor", {8{16'h000F}}, 7'd10, 1'b1);
        issue(T_AH, 3'd0, 7'd12, {4{32'h0001FFFF}}, {4{32'h00000001}}, 18'd0, 1'b1);
        tick();
        wb2("a_carry", {4{32'h00020000}}, 7'd11, 1'b1);
        issue(T_XOR, 3'd0, 7'd13, X, Y, 18'd0, 1'b0);
        tick();
        wb2("ah_nocarry", {4{32'h00010000}}, 7'd12, 1'b1);
        issue(11'b11111111111, 3'd0, 7'd14, X, Y, 18'd0, 1'b1);
        tick();
        wb2("nowrite", {8{16'h0FF0}}, 7'd13, 1'b0);
        issue(T_AH, 3'd1, 7'd15, X, Y, 18'd0, 1'b1);
        tick();
        wb2("unknown_rr", Z0, 7'd0, 1'b0);
        issue({8'hFF, 3'b000}, 3'd3, 7'd16, X, Y, 18'd5, 1'b1);
        tick();
        wb2("bad_format", Z0, 7'd0, 1'b0);

        // ---------------- a, nop, and
        issue(T_A, 3'd0, 7'd20, X, Y, 18'd0, 1'b1);
        tick();
        wb2("unknown_ri10", Z0, 7'd0, 1'b0);
        check("seq_fwd_addr_a", if2.fwd_addr[0], 7'd20);
        issue(T_NOP, 3'd0, 7'd21, X, Y, 18'd0, 1'b1);
        tick();
        wb2("seq_a", {4{32'hEFF1EFF0}}, 7'd20, 1'b1);
        check("seq_fwd_addr_nop", if2.fwd_addr[0], 7'd0);
        issue(T_AND, 3'd0, 7'd22, X, Y, 18'd0, 1'b1);
        tick();
        wb2("seq_nop", Z0, 7'd0, 1'b0);
        check("seq_fwd_addr_and", if2.fwd_addr[0], 7'd22);
        issue(T_NOP, 3'd0, 7'd0, Z0, Z0, 18'd0, 1'b0);
        tick();
        wb2("seq_and", {8{16'hF000}}, 7'd22, 1'b1);

        // ---------------- flush on a full DEPTH=4 pipe
        for (int i = 0; i < 4; i++) begin
            issue(T_OR, 3'd0, 7'(30 + i), X, Y, 18'd0, 1'b1);
            tick();
        end
        check("fill_d4_fwd_wr", if4.fwd_wr, 4'b1111);
        check("fill_d4_fwd_addr0", if4.fwd_addr[0], 7'd33);
        issue(T_OR, 3'd0, 7'd34, X, Y, 18'd0, 1'b1);
        set_flush(1'b1);
        tick();
        set_flush(1'b0);
        check("flush_d4_fwd_wr", if4.fwd_wr, 4'b0000);
        check("flush_d4_fwd_rt", if4.fwd_rt, '0);
        check("flush_d2_wr", if2.reg_write_wb, 1'b0);
        check("flush_d4_wb0", if4.reg_write_wb, 1'b0);
        for (int i = 0; i < 3; i++) begin
            issue(T_OR, 3'd0, 7'(35 + i), X, Y, 18'd0, 1'b1);
            tick();
            check("flush_d4_wb", if4.reg_write_wb, 1'b0);
        end
        issue(T_NOP, 3'd0, 7'd0, Z0, Z0, 18'd0, 1'b0);
        tick();
        check("post_flush_d4_addr", if4.rt_addr_wb, 7'd35);
        check("post_flush_d4_wr",   if4.reg_write_wb, 1'b1);
        check("post_flush_d4_rt",   if4.rt_wb, {8{16'hFFF0}});

        // ---------------- reset (with flush) on a full pipe
        for (int i = 0; i < 4; i++) begin
            issue(T_OR, 3'd0, 7'(40 + i), X, Y, 18'd0, 1'b1);
            tick();
        end
        issue(T_OR, 3'd0, 7'd44, X, Y, 18'd0, 1'b1);
        reset = 1'b1;
        set_flush(1'b1);
        tick();
        reset = 1'b0;
        set_flush(1'b0);
        wb2("rst_mid", Z0, 7'd0, 1'b0);
        check("rst_mid_d4_fwd_rt",   if4.fwd_rt, '0);
        check("rst_mid_d4_fwd_addr", if4.fwd_addr, '0);
        check("rst_mid_d4_fwd_wr",   if4.fwd_wr, '0);
        check("rst_mid_d3_wr",       if3.reg_write_wb, 1'b0);
        issue(T_XOR, 3'd0, 7'd45, X, Y, 18'd0, 1'b1);
        tick();
        check("rst_issue_d2_early", if2.reg_write_wb, 1'b0);
        issue(T_NOP, 3'd0, 7'd0, Z0, Z0, 18'd0, 1'b0);
        tick();
        wb2("rst_issue_d2", {8{16'h0FF0}}, 7'd45, 1'b1);
        check("rst_issue_d3_early", if3.reg_write_wb, 1'b0);
        tick();
        check("rst_issue_d3_addr", if3.rt_addr_wb, 7'd45);
        check("rst_issue_d3_wr",   if3.reg_write_wb, 1'b1);
        check("rst_issue_d4_early", if4.reg_write_wb, 1'b0);
        tick();
        check("rst_issue_d4_addr", if4.rt_addr_wb, 7'd45);
        check("rst_issue_d4_wr",   if4.reg_write_wb, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_simple_fixed_pipe
`default_nettype wire
